// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display path.
package seg_pkg;

    // Index of the digit slot currently being scanned (0 = seconds ones).
    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low gfedcba patterns. Entry [d] holds the pattern for digit d.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Non-BCD codes never reach this in normal use; show them dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        if (digit > 4'd9) pattern = SEG_BLANK;
        else              pattern = SEG_DIGITS[digit];
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// Binary 0..63 to two BCD digits, clamping anything above 59.
module bin2bcd_60 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [5:0] sat;

    // Clamp to 59, then split into tens and ones.
    always_comb begin
        sat  = (bin > 6'd59) ? 6'd59 : bin;
        tens = 4'(sat / 6'd10);
        ones = 4'(sat % 6'd10);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit MM:SS display driver with optional field blinking.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       blink,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    digit_idx_t         idx;
    logic               scan_tc;
    logic               frame_tc;
    logic               blink_tc;
    logic               phase;

    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic       blink_q;
    logic       sel_q;

    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    logic [3:0] digit;
    logic       blanked;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    assign scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign frame_tc = scan_tc && (idx == 2'd3);
    assign blink_tc = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

    // Slot timer and digit index; idx steps once per completed slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_tc) begin
            scan_cnt <= '0;
            idx      <= digit_idx_t'(idx + 2'd1);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Capture inputs only at frame boundaries so a frame never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q   <= '0;
            sec_q   <= '0;
            blink_q <= 1'b0;
            sel_q   <= 1'b0;
        end else if (frame_tc) begin
            min_q   <= min;
            sec_q   <= sec;
            blink_q <= blink;
            sel_q   <= sel;
        end
    end

    // Blink half-period timer; also cleared when a frame loads blink=0 so
    // the next blink session always opens on the visible phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!blink_q || (frame_tc && !blink)) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_tc) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    bin2bcd_60 u_min_bcd (
        .bin  (min_q),
        .tens (min_tens),
        .ones (min_ones)
    );

    bin2bcd_60 u_sec_bcd (
        .bin  (sec_q),
        .tens (sec_tens),
        .ones (sec_ones)
    );

    // Pick the digit for the current slot and decide whether it is blanked.
    always_comb begin
        digit   = 4'd0;
        blanked = 1'b0;
        an_d    = AN_OFF;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        case (idx)
            2'd0:    digit = sec_ones;
            2'd1:    digit = sec_tens;
            2'd2:    digit = min_ones;
            default: digit = min_tens;
        endcase
        blanked = blink_q && phase && (sel_q ? (idx <= 2'd1) : (idx >= 2'd2));
        if (!blanked) begin
            an_d      = AN_OFF;
            an_d[idx] = 1'b0;
            seg_d     = seg_encode(digit);
            dp_d      = (idx == 2'd2) ? 1'b0 : 1'b1;
        end
    end

    // Register the pins so they change cleanly one cycle after idx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
